fcvt_seq_unit: RTL

Multi-cycle, synthesizable RV32F conversion unit for FCVT.S.W, FCVT.S.WU, FCVT.W.S and FCVT.WU.S. It is the issue-side neighbour of the DSP float conversion stage: operands arrive through a valid/ready handshake from the execute stage, and results plus IEEE-754 flags return to writeback through a second valid/ready handshake. It uses an iterative one-bit normaliser with round-to-nearest-even, so no real/shortreal arithmetic is needed.

---
 rtl/fcvt_seq_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fcvt_seq_unit.sv
// RV32F FCVT.S.W/S.WU/W.S/WU.S converter using a one-bit-per-cycle normaliser with RNE rounding.
// Latency: accept at T, out_valid at T+3+k (k = NORM shifts); zero/NaN/Inf/overflow cases at T+1.
// Backpressure: in_ready only in IDLE; result/fflags held in DONE until out_ready, no request queueing.
module fcvt_seq_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        sign_q;
    logic [31:0] sig_q;      // integer magnitude (S.*) or significand (W.*)
    logic [7:0]  exp_q;      // running binary32 exponent for int->float
    logic [7:0]  cnt_q;      // remaining shifts for float->int
    logic        left_q;     // float->int shift direction
    logic        guard_q;
    logic        sticky_q;

    // Request classification, evaluated on the incoming operand
    logic [7:0]  f_exp;
    logic [22:0] f_mant;
    logic        in_neg;
    logic [31:0] in_mag;
    logic        is_nan;
    logic        is_sat;
    logic [31:0] sat_val;
    logic [7:0]  rsh;
    logic [7:0]  cnt_in;

    // Decode the incoming operand into sign/magnitude, special cases and shift count
    always_comb begin
        f_exp   = operand[30:23];
        f_mant  = operand[22:0];
        in_neg  = ~op[0] & operand[31];
        in_mag  = in_neg ? (~operand + 32'd1) : operand;
        is_nan  = (f_exp == 8'hFF) && (f_mant != 23'd0);
        is_sat  = (f_exp >= 8'd159);
        if (is_nan)
            sat_val = op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        else if (operand[31])
            sat_val = op[0] ? 32'h0000_0000 : 32'h8000_0000;
        else
            sat_val = op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        rsh = 8'd150 - f_exp;
        if (f_exp > 8'd150)
            cnt_in = f_exp - 8'd150;
        else if (rsh > 8'd26)
            cnt_in = 8'd26;
        else
            cnt_in = rsh;
    end

    // Rounding of the normalised state
    logic [23:0]        frac_sum;
    logic               i_up;
    logic               i_nx;
    logic [7:0]         i_exp;
    logic [31:0]        i2f_res;
    logic               f_up;
    logic [32:0]        f_mag;
    logic signed [33:0] f_val;
    logic [31:0]        f2i_res;
    logic               f_nv;
    logic               f_nx;

    // RNE for both directions plus the float->int range check on the rounded value
    always_comb begin
        i_nx     = sig_q[7] | (|sig_q[6:0]);
        i_up     = sig_q[7] & ((|sig_q[6:0]) | sig_q[8]);
        frac_sum = {1'b0, sig_q[30:8]} + {23'd0, i_up};
        i_exp    = exp_q + {7'd0, frac_sum[23]};
        i2f_res  = {sign_q, i_exp, frac_sum[22:0]};

        f_up    = guard_q & (sticky_q | sig_q[0]);
        f_mag   = {1'b0, sig_q} + {32'd0, f_up};
        f_val   = sign_q ? -$signed({1'b0, f_mag}) : $signed({1'b0, f_mag});
        f_nx    = guard_q | sticky_q;
        f_nv    = 1'b0;
        f2i_res = f_val[31:0];
        if (!op_q[0]) begin
            if (f_val > 34'sd2147483647 || f_val < -34'sd2147483648) begin
                f2i_res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                f_nv    = 1'b1;
                f_nx    = 1'b0;
            end
        end else begin
            if (f_val < 34'sd0) begin
                f2i_res = 32'h0000_0000;
                f_nv    = 1'b1;
                f_nx    = 1'b0;
            end else if (f_val > 34'sd4294967295) begin
                f2i_res = 32'hFFFF_FFFF;
                f_nv    = 1'b1;
                f_nx    = 1'b0;
            end
        end
    end

    assign in_ready = (state == IDLE);

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= 2'd0;
            sign_q    <= 1'b0;
            sig_q     <= 32'd0;
            exp_q     <= 8'd0;
            cnt_q     <= 8'd0;
            left_q    <= 1'b0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            out_valid <= 1'b0;
            result    <= 32'd0;
            fflags    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        guard_q  <= 1'b0;
                        sticky_q <= 1'b0;
                        if (!op[1]) begin
                            sign_q <= in_neg;
                            sig_q  <= in_mag;
                            exp_q  <= 8'd158;
                            left_q <= 1'b1;
                            if (in_mag == 32'd0) begin
                                result <= 32'd0;
                                fflags <= 5'd0;
                                state  <= DONE;
                            end else begin
                                state  <= NORM;
                            end
                        end else begin
                            sign_q <= operand[31];
                            sig_q  <= {8'd0, (f_exp != 8'd0), f_mant};
                            exp_q  <= f_exp;
                            left_q <= (f_exp > 8'd150);
                            cnt_q  <= cnt_in;
                            if (is_sat) begin
                                result <= sat_val;
                                fflags <= 5'b10000;
                                state  <= DONE;
                            end else begin
                                state  <= NORM;
                            end
                        end
                    end
                end
                NORM: begin
                    if (!op_q[1]) begin
                        if (!sig_q[31]) begin
                            sig_q <= {sig_q[30:0], 1'b0};
                            exp_q <= exp_q - 8'd1;
                        end else begin
                            state <= ROUND;
                        end
                    end else if (cnt_q == 8'd0) begin
                        state <= ROUND;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                        if (left_q) begin
                            sig_q <= {sig_q[30:0], 1'b0};
                        end else begin
                            sig_q    <= {1'b0, sig_q[31:1]};
                            guard_q  <= sig_q[0];
                            sticky_q <= sticky_q | guard_q;
                        end
                    end
                end
                ROUND: begin
                    result <= op_q[1] ? f2i_res : i2f_res;
                    fflags <= op_q[1] ? {f_nv, 3'b000, f_nx} : {4'b0000, i_nx};
                    state  <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
